if_id_stage_ctrl: RTL and testbench

//  Owns the IF/ID pipeline register and sequences the instruction field splitter that sits behind it.

---
 rtl/if_id_stage_ctrl.sv | 109 ++++++++++
 tb/tb_if_id_stage_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_ctrl.sv
// IF/ID pipeline register and its advance/hold/flush sequencer.
// Handles load-use stalls against EX, HALT freeze and debug single-step gating.
module if_id_stage_ctrl #(
  parameter int                NB_DATA = 32,
  parameter int                NB_REG  = 5,
  parameter int                NB_OP   = 6,
  parameter logic [NB_OP-1:0]  HALT_OP = 6'h3F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_DATA-1:0] i_instruction,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic               i_ex_mem_read,
  input  logic [NB_REG-1:0]  i_ex_rt,
  input  logic               i_branch_taken,
  input  logic               i_step_mode,
  input  logic               i_step,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_valid,
  output logic               o_pc_write,
  output logic               o_bubble,
  output logic               o_halted
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic               valid_q, valid_d;

  logic [NB_REG-1:0]  held_rs, held_rt;
  logic [NB_OP-1:0]   fetch_op;
  logic               haz;
  logic               step_hold;
  logic               pc_write;
  logic               bubble;

  assign held_rs  = instr_q[21 +: NB_REG];
  assign held_rt  = instr_q[16 +: NB_REG];
  assign fetch_op = i_instruction[NB_DATA-1 -: NB_OP];

  // A bubble in IF/ID can never be the consumer of a load, hence the valid term.
  assign haz = i_ex_mem_read && (i_ex_rt != '0) && valid_q &&
               ((i_ex_rt == held_rs) || (i_ex_rt == held_rt));

  assign step_hold = i_step_mode && !i_step;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    state_d  = ST_RUN;
    pc_write = 1'b1;
    bubble   = 1'b0;

    if (state_q == ST_HALT) begin
      state_d  = ST_HALT;
      pc_write = 1'b0;
      bubble   = 1'b1;
    end else if (i_branch_taken) begin
      instr_d  = '0;
      pc_d     = '0;
      valid_d  = 1'b0;
    end else if (haz) begin
      state_d  = ST_STALL;
      pc_write = 1'b0;
      bubble   = 1'b1;
    end else if (step_hold) begin
      state_d  = ST_STEP;
      pc_write = 1'b0;
      bubble   = 1'b1;
    end else begin
      instr_d  = i_instruction;
      pc_d     = i_pc;
      valid_d  = 1'b1;
      // The HALT word itself is kept in IF/ID; the freeze starts next cycle.
      if (fetch_op == HALT_OP) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_valid       = valid_q;
  assign o_pc_write    = pc_write;
  assign o_bubble      = bubble;
  assign o_halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Randomized and directed bench for if_id_stage_ctrl with a cycle-level reference model.
module tb_if_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_instruction, i_pc;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt;
  logic        i_branch_taken, i_step_mode, i_step;
  logic [31:0] o_instruction, o_pc;
  logic        o_valid, o_pc_write, o_bubble, o_halted;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: what IF/ID holds and whether the pipeline is frozen
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  if_id_stage_ctrl dut (
    .clk(clk), .reset(reset),
    .i_instruction(i_instruction), .i_pc(i_pc),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .i_branch_taken(i_branch_taken), .i_step_mode(i_step_mode), .i_step(i_step),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_valid(o_valid),
    .o_pc_write(o_pc_write), .o_bubble(o_bubble), .o_halted(o_halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // One clock: compare against the model on the falling edge, then advance the model.
  task automatic cyc();
    logic haz, hold;
    logic exp_pcw, exp_bub;
    logic [31:0] n_instr, n_pc;
    logic n_valid, n_halted;
    @(negedge clk);
    haz = i_ex_mem_read && i_ex_rt != 0 && m_valid &&
          (i_ex_rt == m_instr[25:21] || i_ex_rt == m_instr[20:16]);
    n_instr = m_instr; n_pc = m_pc; n_valid = m_valid; n_halted = m_halted;
    exp_pcw = 1'b1; exp_bub = 1'b0;
    hold = 1'b0;
    if (m_halted) begin
      exp_pcw = 0; exp_bub = 1;
    end else if (i_branch_taken) begin
      n_instr = 0; n_pc = 0; n_valid = 0;
    end else if (haz || (i_step_mode && !i_step)) begin
      exp_pcw = 0; exp_bub = 1; hold = 1;
    end else begin
      n_instr = i_instruction; n_pc = i_pc; n_valid = 1;
      n_halted = (i_instruction[31:26] == 6'h3F);
    end
    if (reset) begin
      n_instr = 0; n_pc = 0; n_valid = 0; n_halted = 0;
    end else begin
      chk("pc_write", {31'd0, o_pc_write}, {31'd0, exp_pcw});
      chk("bubble", {31'd0, o_bubble}, {31'd0, exp_bub});
    end
    chk("instruction", o_instruction, m_instr);
    chk("pc", o_pc, m_pc);
    chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, o_halted}, {31'd0, m_halted});
    if (hold) ; // held word stays in the model unchanged
    @(posedge clk);
    #1;
    m_instr = n_instr; m_pc = n_pc; m_valid = n_valid; m_halted = n_halted;
  endtask

  task automatic idle_inputs();
    i_ex_mem_read = 0; i_ex_rt = 0; i_branch_taken = 0;
    i_step_mode = 0; i_step = 0; reset = 0;
  endtask

  task automatic do_reset();
    reset = 1; cyc(); reset = 0;
  endtask

  initial begin
    logic [31:0] held;
    idle_inputs();
    i_instruction = 0; i_pc = 0;
    m_instr = 'x; m_pc = 'x; m_valid = 'x; m_halted = 'x;
    reset = 1;
    @(posedge clk); #1;
    m_instr = 0; m_pc = 0; m_valid = 0; m_halted = 0;
    do_reset();

    // reset state, combinational outputs in RUN
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_halted", {31'd0, o_halted}, 32'd0);
    chk("rst_pcw", {31'd0, o_pc_write}, 32'd1);
    chk("rst_bubble", {31'd0, o_bubble}, 32'd0);

    // plain streaming
    i_instruction = 32'h8C220004; i_pc = 32'h4; cyc();
    chk("stream0", o_instruction, 32'h8C220004);
    chk("stream0_pc", o_pc, 32'h4);
    i_instruction = 32'h00221820; i_pc = 32'h8; cyc();
    chk("stream1", o_instruction, 32'h00221820);
    chk("stream1_valid", {31'd0, o_valid}, 32'd1);

    // load-use stall on rt=2
    i_instruction = 32'h00853020; i_pc = 32'hC;
    i_ex_mem_read = 1; i_ex_rt = 2; #1;
    chk("stall_pcw", {31'd0, o_pc_write}, 32'd0);
    chk("stall_bubble", {31'd0, o_bubble}, 32'd1);
    cyc();
    chk("stall_hold", o_instruction, 32'h00221820);
    i_ex_mem_read = 0; cyc();
    chk("stall_release", o_instruction, 32'h00853020);
    // rt=0 never stalls
    i_instruction = 32'h00001020; i_ex_mem_read = 1; i_ex_rt = 0; #1;
    chk("rt0_pcw", {31'd0, o_pc_write}, 32'd1);
    cyc();
    // hazard on rs=0 word is impossible; reload a word using r1/r2 then flush under hazard
    i_ex_mem_read = 0; i_instruction = 32'h00221820; i_pc = 32'h10; cyc();
    i_ex_mem_read = 1; i_ex_rt = 1; i_branch_taken = 1; #1;
    chk("flush_pcw", {31'd0, o_pc_write}, 32'd1);
    cyc();
    chk("flush_instr", o_instruction, 32'h0);
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    idle_inputs();

    // step mode
    i_instruction = 32'h01095020; i_pc = 32'h20; cyc();
    held = o_instruction;
    i_step_mode = 1; i_instruction = 32'h012A5820; i_pc = 32'h24;
    for (int k = 0; k < 5; k++) begin
      #1 chk("step_bubble", {31'd0, o_bubble}, 32'd1);
      cyc();
      chk("step_hold", o_instruction, held);
    end
    i_step = 1; cyc(); i_step = 0;
    chk("step_adv", o_instruction, 32'h012A5820);
    i_instruction = 32'h014B6020; cyc();
    chk("step_once", o_instruction, 32'h012A5820);

    // reset during STEP wait, then during STALL
    reset = 1; cyc(); reset = 0;
    chk("rst_step_valid", {31'd0, o_valid}, 32'd0);
    i_step_mode = 0; i_instruction = 32'h00221820; cyc();
    i_ex_mem_read = 1; i_ex_rt = 1; cyc();
    reset = 1; cyc(); reset = 0;
    chk("rst_stall_instr", o_instruction, 32'h0);
    idle_inputs();

    // HALT
    i_instruction = 32'hFC000000; i_pc = 32'h40; cyc();
    chk("halt_flag", {31'd0, o_halted}, 32'd1);
    i_instruction = 32'h00221820; i_branch_taken = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("halt_pcw", {31'd0, o_pc_write}, 32'd0);
      cyc();
    end
    chk("halt_keep", o_instruction, 32'hFC000000);
    idle_inputs();
    do_reset();
    chk("halt_rst", {31'd0, o_halted}, 32'd0);
    chk("halt_rst_valid", {31'd0, o_valid}, 32'd0);

    // randomized traffic, small register numbers so hazards are common
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] w;
      w = $urandom;
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      if (w[31:26] == 6'h3F || $urandom_range(0, 199) == 0)
        w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h23;
      i_instruction  = w;
      i_pc           = $urandom;
      i_ex_mem_read  = ($urandom_range(0, 2) == 0);
      i_ex_rt        = 5'($urandom_range(0, 3));
      i_branch_taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) i_step_mode = ~i_step_mode;
      i_step         = ($urandom_range(0, 2) == 0);
      reset          = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
